// File: rtl/acc_8bit_dual_if.sv
// Bundle of the product/bias beat stream and the requantised result stream
// between the dual multiplier, the accumulator and its downstream consumer.
// Ports: master = producer/consumer side (drives beats and o_ready), slave = the accumulator.
interface acc_8bit_dual_if;
  logic signed [15:0] prod_ac;
  logic signed [15:0] prod_bc;
  logic signed [15:0] bias_ac;
  logic signed [15:0] bias_bc;
  logic               i_valid;
  logic               i_last;
  logic               i_ready;
  logic signed [7:0]  out_ac;
  logic signed [7:0]  out_bc;
  logic               o_valid;
  logic               o_ready;
  logic               o_len_err;

  modport master (
    output prod_ac, prod_bc, bias_ac, bias_bc, i_valid, i_last, o_ready,
    input  i_ready, out_ac, out_bc, o_valid, o_len_err
  );

  modport slave (
    input  prod_ac, prod_bc, bias_ac, bias_bc, i_valid, i_last, o_ready,
    output i_ready, out_ac, out_bc, o_valid, o_len_err
  );
endinterface

// File: rtl/acc_8bit_dual.sv
// Dual-channel vector accumulator: sums signed 16-bit products plus a per-vector bias,
// then requantises each sum to int8 (round-half-up shift + saturate) at vector end.
// Ports: clk, rst_n (async active-low), bus (acc_8bit_dual_if.slave: beat input, result output).
// Latency: result valid the cycle after the terminating beat; i_ready = ~o_valid | o_ready.
// Optional macro ACC_DUAL_RELU_EN: clamp negative results to 0 after saturation.
module acc_8bit_dual #(
  parameter int ACC_WIDTH = 24,
  parameter int OUT_SHIFT = 7,
  parameter int MAX_LEN   = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  acc_8bit_dual_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int WW    = ACC_WIDTH + 1;

  // Rounding constant for the extra-wide add; zero when no shift is applied.
  localparam logic signed [WW-1:0] RND =
    (OUT_SHIFT > 0) ? (WW'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [WW-1:0] SAT_MAX = WW'(127);
  localparam logic signed [WW-1:0] SAT_MIN = -WW'(128);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                      r_state;
  logic signed [ACC_WIDTH-1:0] r_acc_ac;
  logic signed [ACC_WIDTH-1:0] r_acc_bc;
  logic        [CNT_W-1:0]     r_cnt;
  logic signed [7:0]           r_out_ac;
  logic signed [7:0]           r_out_bc;
  logic                        r_len_err;

  logic                        w_accept;
  logic                        w_xfer;
  logic                        w_first;
  logic                        w_force;
  logic                        w_term;
  logic signed [ACC_WIDTH-1:0] w_base_ac;
  logic signed [ACC_WIDTH-1:0] w_base_bc;
  logic signed [ACC_WIDTH-1:0] w_next_ac;
  logic signed [ACC_WIDTH-1:0] w_next_bc;

  // The rounding add is one bit wider than the accumulator so it cannot wrap.
  function automatic logic signed [7:0] requant(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [WW-1:0] wide;
    logic signed [WW-1:0] shr;
    logic signed [7:0]    sat;
    wide = WW'(v) + RND;
    shr  = wide >>> OUT_SHIFT;
    if (shr > SAT_MAX) begin
      sat = 8'sh7F;
    end else if (shr < SAT_MIN) begin
      sat = 8'sh80;
    end else begin
      sat = shr[7:0];
    end
`ifdef ACC_DUAL_RELU_EN
    if (sat[7]) begin
      sat = 8'sh00;
    end
`endif
    return sat;
  endfunction

  assign bus.i_ready   = (r_state == ACCUM) | bus.o_ready;
  assign bus.o_valid   = (r_state == HOLD);
  assign bus.out_ac    = r_out_ac;
  assign bus.out_bc    = r_out_bc;
  assign bus.o_len_err = r_len_err;

  assign w_accept = bus.i_valid & bus.i_ready;
  assign w_xfer   = bus.o_valid & bus.o_ready;
  assign w_first  = (r_cnt == '0);
  assign w_force  = (r_cnt == CNT_W'(MAX_LEN - 1));
  assign w_term   = bus.i_last | w_force;

  // First beat of a vector starts from the bias instead of the running sum.
  assign w_base_ac = w_first ? ACC_WIDTH'(bus.bias_ac) : r_acc_ac;
  assign w_base_bc = w_first ? ACC_WIDTH'(bus.bias_bc) : r_acc_bc;
  assign w_next_ac = w_base_ac + ACC_WIDTH'(bus.prod_ac);
  assign w_next_bc = w_base_bc + ACC_WIDTH'(bus.prod_bc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_acc_ac  <= '0;
      r_acc_bc  <= '0;
      r_cnt     <= '0;
      r_out_ac  <= '0;
      r_out_bc  <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_term) begin
          r_out_ac <= requant(w_next_ac);
          r_out_bc <= requant(w_next_bc);
          r_acc_ac <= '0;
          r_acc_bc <= '0;
          r_cnt    <= '0;
          if (!bus.i_last) begin
            r_len_err <= 1'b1;
          end
        end else begin
          r_acc_ac <= w_next_ac;
          r_acc_bc <= w_next_bc;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
      end
      // A new result loading in the same cycle as a transfer keeps HOLD.
      if (w_accept && w_term) begin
        r_state <= HOLD;
      end else if (w_xfer) begin
        r_state <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_acc_8bit_dual.sv
module tb_acc_8bit_dual;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  acc_8bit_dual_if bus_if ();

  acc_8bit_dual #(
    .ACC_WIDTH (24),
    .OUT_SHIFT (7),
    .MAX_LEN   (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected value after the optional negative clamp.
  function automatic logic signed [7:0] relu(input logic signed [7:0] v);
`ifdef ACC_DUAL_RELU_EN
    return v[7] ? 8'sh00 : v;
`else
    return v;
`endif
  endfunction

  task automatic beat(input logic signed [15:0] pa, input logic signed [15:0] pb,
                      input logic signed [15:0] ba, input logic signed [15:0] bb,
                      input logic last);
    bus_if.prod_ac = pa;
    bus_if.prod_bc = pb;
    bus_if.bias_ac = ba;
    bus_if.bias_bc = bb;
    bus_if.i_valid = 1'b1;
    bus_if.i_last  = last;
    @(posedge clk);
    #1;
    bus_if.i_valid = 1'b0;
    bus_if.i_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_if.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %0b want 0", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd0) begin errors++; $display("FAIL reset_out_ac: got %0d want 0", bus_if.out_ac); end
    checks++; if (bus_if.out_bc !== 8'sd0) begin errors++; $display("FAIL reset_out_bc: got %0d want 0", bus_if.out_bc); end
    checks++; if (bus_if.o_len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %0b want 0", bus_if.o_len_err); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checks++; if (bus_if.i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %0b want 1", bus_if.i_ready); end
  endtask

  task automatic test_basic();
    beat(16'sd100, -16'sd100, 16'sd0, 16'sd0, 1'b0);
    beat(16'sd200, -16'sd200, 16'sd0, 16'sd0, 1'b0);
    checks++; if (bus_if.o_valid !== 1'b0) begin errors++; $display("FAIL basic_midvec_valid: got %0b want 0", bus_if.o_valid); end
    beat(16'sd300, -16'sd300, 16'sd0, 16'sd0, 1'b1);
    checks++; if (bus_if.o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd5) begin errors++; $display("FAIL basic_out_ac: got %0d want 5", bus_if.out_ac); end
    checks++; if (bus_if.out_bc !== relu(-8'sd5)) begin errors++; $display("FAIL basic_out_bc: got %0d want %0d", bus_if.out_bc, relu(-8'sd5)); end
    idle();
    checks++; if (bus_if.o_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %0b want 0", bus_if.o_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) beat(16'sd16000, -16'sd16000, 16'sd0, 16'sd0, (i == 3));
    checks++; if (bus_if.out_ac !== 8'sd127) begin errors++; $display("FAIL sat_out_ac: got %0d want 127", bus_if.out_ac); end
    checks++; if (bus_if.out_bc !== relu(-8'sd128)) begin errors++; $display("FAIL sat_out_bc: got %0d want %0d", bus_if.out_bc, relu(-8'sd128)); end
    checks++; if (bus_if.o_len_err !== 1'b0) begin errors++; $display("FAIL sat_len_err: got %0b want 0", bus_if.o_len_err); end
    idle();
  endtask

  task automatic test_bias_back_to_back();
    beat(16'sd0, 16'sd0, 16'sd128, -16'sd129, 1'b1);
    checks++; if (bus_if.out_ac !== 8'sd1) begin errors++; $display("FAIL bias_out_ac: got %0d want 1", bus_if.out_ac); end
    checks++; if (bus_if.out_bc !== relu(-8'sd1)) begin errors++; $display("FAIL bias_out_bc: got %0d want %0d", bus_if.out_bc, relu(-8'sd1)); end
    beat(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b1);
    checks++; if (bus_if.o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd0) begin errors++; $display("FAIL b2b_out_ac: got %0d want 0", bus_if.out_ac); end
    checks++; if (bus_if.out_bc !== 8'sd0) begin errors++; $display("FAIL b2b_out_bc: got %0d want 0", bus_if.out_bc); end
    idle();
  endtask

  task automatic test_backpressure();
    beat(16'sd640, -16'sd640, 16'sd0, 16'sd0, 1'b1);
    bus_if.o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_if.prod_ac = 16'sd1000;
      bus_if.prod_bc = 16'sd1000;
      bus_if.i_valid = 1'b1;
      bus_if.i_last  = i[0];
      idle();
      checks++; if (bus_if.i_ready !== 1'b0) begin errors++; $display("FAIL bp_i_ready[%0d]: got %0b want 0", i, bus_if.i_ready); end
      checks++; if (bus_if.o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, bus_if.o_valid); end
      checks++; if (bus_if.out_ac !== 8'sd5) begin errors++; $display("FAIL bp_out_ac[%0d]: got %0d want 5", i, bus_if.out_ac); end
      checks++; if (bus_if.out_bc !== relu(-8'sd5)) begin errors++; $display("FAIL bp_out_bc[%0d]: got %0d want %0d", i, bus_if.out_bc, relu(-8'sd5)); end
    end
    bus_if.i_valid = 1'b0;
    bus_if.i_last  = 1'b0;
    bus_if.o_ready = 1'b1;
    #1;
    checks++; if (bus_if.i_ready !== 1'b1) begin errors++; $display("FAIL bp_release_i_ready: got %0b want 1", bus_if.i_ready); end
    beat(16'sd256, -16'sd256, 16'sd0, 16'sd0, 1'b1);
    checks++; if (bus_if.o_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid: got %0b want 1", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd2) begin errors++; $display("FAIL bp_reload_out_ac: got %0d want 2", bus_if.out_ac); end
    checks++; if (bus_if.out_bc !== relu(-8'sd2)) begin errors++; $display("FAIL bp_reload_out_bc: got %0d want %0d", bus_if.out_bc, relu(-8'sd2)); end
    idle();
    checks++; if (bus_if.o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %0b want 0", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd2) begin errors++; $display("FAIL bp_retain_out_ac: got %0d want 2", bus_if.out_ac); end
  endtask

  task automatic test_len_err();
    for (int i = 0; i < 3; i++) beat(16'sd128, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    checks++; if (bus_if.o_valid !== 1'b0) begin errors++; $display("FAIL len_pre_valid: got %0b want 0", bus_if.o_valid); end
    beat(16'sd128, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    checks++; if (bus_if.o_valid !== 1'b1) begin errors++; $display("FAIL len_forced_valid: got %0b want 1", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd4) begin errors++; $display("FAIL len_out_ac: got %0d want 4", bus_if.out_ac); end
    checks++; if (bus_if.o_len_err !== 1'b1) begin errors++; $display("FAIL len_err_set: got %0b want 1", bus_if.o_len_err); end
    idle();
    checks++; if (bus_if.o_len_err !== 1'b1) begin errors++; $display("FAIL len_err_sticky: got %0b want 1", bus_if.o_len_err); end
    beat(16'sd0, 16'sd0, 16'sd128, 16'sd0, 1'b1);
    checks++; if (bus_if.out_ac !== 8'sd1) begin errors++; $display("FAIL len_next_out_ac: got %0d want 1", bus_if.out_ac); end
    checks++; if (bus_if.o_len_err !== 1'b1) begin errors++; $display("FAIL len_err_sticky2: got %0b want 1", bus_if.o_len_err); end
    idle();
  endtask

  task automatic test_reset_mid_vector();
    beat(16'sd1000, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    beat(16'sd1000, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd0) begin errors++; $display("FAIL rstmid_out_ac: got %0d want 0", bus_if.out_ac); end
    checks++; if (bus_if.o_len_err !== 1'b0) begin errors++; $display("FAIL rstmid_len_err: got %0b want 0", bus_if.o_len_err); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    beat(16'sd256, 16'sd0, 16'sd0, 16'sd0, 1'b1);
    checks++; if (bus_if.o_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %0b want 1", bus_if.o_valid); end
    checks++; if (bus_if.out_ac !== 8'sd2) begin errors++; $display("FAIL rstmid_new_out_ac: got %0d want 2", bus_if.out_ac); end
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n          = 1'b0;
    bus_if.prod_ac = '0;
    bus_if.prod_bc = '0;
    bus_if.bias_ac = '0;
    bus_if.bias_bc = '0;
    bus_if.i_valid = 1'b0;
    bus_if.i_last  = 1'b0;
    bus_if.o_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_bias_back_to_back();
    test_backpressure();
    test_len_err();
    test_reset_mid_vector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
